// File: rtl/wb_pkg.sv
// Shared state encoding, response-vector layout and sizing helper for the
// Wishbone decode crossbar.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_BUSY   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Bit positions inside the one-hot master response vector.
  localparam int unsigned RSP_W   = 3;
  localparam int unsigned RSP_ACK = 0;
  localparam int unsigned RSP_ERR = 1;
  localparam int unsigned RSP_RTY = 2;

  // Index width that never collapses to zero bits for tiny slave counts.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Mask/match address decode with fixed priority: the lowest matching slave
// index wins.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES = 5,
  parameter int unsigned              AW         = 32,
  parameter int unsigned              IW         = clog2_min1(NUM_SLAVES),
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0
) (
  input  logic [AW-1:0] i_adr,
  output logic          o_hit_c,
  output logic [IW-1:0] o_idx_c
);

  logic [NUM_SLAVES-1:0] w_match;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      w_match[i] = ((i_adr ^ MATCH_ADDR[i*AW +: AW]) & MATCH_MASK[i*AW +: AW]) == '0;
    end
  end

  // Walk from the top so the lowest matching index is the last one written.
  always_comb begin
    o_hit_c = 1'b0;
    o_idx_c = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        o_hit_c = 1'b1;
        o_idx_c = IW'(i);
      end
    end
  end

endmodule

// File: rtl/wb_decode_xbar.sv
// Single-master Wishbone router: registered decode, per-transaction ack
// watchdog, decode-error reporting and a write-once fault record.
module wb_decode_xbar
  import wb_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES = 5,
  parameter int unsigned              AW         = 32,
  parameter int unsigned              DW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = {32'h0004_0000, 32'h0003_0000,
                                                    32'h0002_0000, 32'h0001_0000,
                                                    32'h0000_0000},
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = {NUM_SLAVES{32'hFFFF_0000}},
  parameter int unsigned              TIMEOUT    = 255,
  parameter int unsigned              TW         = 8
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [AW-1:0]              wbm_adr_i,
  input  logic [DW-1:0]              wbm_dat_i,
  input  logic [DW/8-1:0]            wbm_sel_i,
  input  logic                       wbm_we_i,
  input  logic                       wbm_stb_i,
  input  logic                       wbm_cyc_i,
  output logic [DW-1:0]              wbm_dat_o,
  output logic                       wbm_ack_o,
  output logic                       wbm_err_o,
  output logic                       wbm_rty_o,
  output logic [NUM_SLAVES*AW-1:0]   wbs_adr_o,
  output logic [NUM_SLAVES*DW-1:0]   wbs_dat_o,
  output logic [NUM_SLAVES*DW/8-1:0] wbs_sel_o,
  output logic [NUM_SLAVES-1:0]      wbs_we_o,
  output logic [NUM_SLAVES-1:0]      wbs_stb_o,
  output logic [NUM_SLAVES-1:0]      wbs_cyc_o,
  input  logic [NUM_SLAVES*DW-1:0]   wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]      wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]      wbs_err_i,
  input  logic [NUM_SLAVES-1:0]      wbs_rty_i,
  output logic                       fault_o,
  output logic [AW-1:0]              fault_adr_o,
  output logic                       fault_to_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = clog2_min1(NUM_SLAVES);

  state_e                r_state,     w_state_nxt;
  logic [AW-1:0]         r_adr,       w_adr_nxt;
  logic [DW-1:0]         r_dat,       w_dat_nxt;
  logic [SW-1:0]         r_sel,       w_sel_nxt;
  logic                  r_we,        w_we_nxt;
  logic [IW-1:0]         r_idx,       w_idx_nxt;
  logic [NUM_SLAVES-1:0] r_stb,       w_stb_nxt;
  logic [TW-1:0]         r_wd,        w_wd_nxt;
  logic [RSP_W-1:0]      r_rsp,       w_rsp_nxt;
  logic [DW-1:0]         r_rdat,      w_rdat_nxt;
  logic                  r_fault,     w_fault_nxt;
  logic [AW-1:0]         r_fault_adr, w_fault_adr_nxt;
  logic                  r_fault_to,  w_fault_to_nxt;

  logic          w_hit;
  logic [IW-1:0] w_dec_idx;
  logic          w_s_ack;
  logic          w_s_err;
  logic          w_s_rty;
  logic [DW-1:0] w_s_dat;
  logic          w_wd_expire;
  logic          w_fault_set;
  logic          w_fault_is_to;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .AW         (AW),
    .IW         (IW),
    .MATCH_ADDR (MATCH_ADDR),
    .MATCH_MASK (MATCH_MASK)
  ) u_dec (
    .i_adr   (r_adr),
    .o_hit_c (w_hit),
    .o_idx_c (w_dec_idx)
  );

  assign w_s_ack     = wbs_ack_i[r_idx];
  assign w_s_err     = wbs_err_i[r_idx];
  assign w_s_rty     = wbs_rty_i[r_idx];
  assign w_s_dat     = wbs_dat_i[32'(r_idx) * DW +: DW];
  assign w_wd_expire = (TIMEOUT != 0) && (r_wd == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_adr_nxt       = r_adr;
    w_dat_nxt       = r_dat;
    w_sel_nxt       = r_sel;
    w_we_nxt        = r_we;
    w_idx_nxt       = r_idx;
    w_stb_nxt       = r_stb;
    w_wd_nxt        = r_wd;
    w_rsp_nxt       = '0;
    w_rdat_nxt      = r_rdat;
    w_fault_nxt     = r_fault;
    w_fault_adr_nxt = r_fault_adr;
    w_fault_to_nxt  = r_fault_to;
    w_fault_set     = 1'b0;
    w_fault_is_to   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          w_adr_nxt   = wbm_adr_i;
          w_dat_nxt   = wbm_dat_i;
          w_sel_nxt   = wbm_sel_i;
          w_we_nxt    = wbm_we_i;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!wbm_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hit) begin
          w_idx_nxt   = w_dec_idx;
          w_stb_nxt   = NUM_SLAVES'(1) << w_dec_idx;
          w_wd_nxt    = '0;
          w_state_nxt = ST_BUSY;
        end else begin
          w_rsp_nxt[RSP_ERR] = 1'b1;
          w_fault_set        = 1'b1;
          w_state_nxt        = ST_RESP;
        end
      end
      ST_BUSY: begin
        // A slave response in the expiry cycle takes precedence over the watchdog.
        if (!wbm_cyc_i) begin
          w_stb_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_s_ack || w_s_err || w_s_rty) begin
          w_rsp_nxt[RSP_ACK] = w_s_ack;
          w_rsp_nxt[RSP_ERR] = !w_s_ack && w_s_err;
          w_rsp_nxt[RSP_RTY] = !w_s_ack && !w_s_err;
          w_rdat_nxt         = w_s_dat;
          w_stb_nxt          = '0;
          w_state_nxt        = ST_RESP;
        end else if (w_wd_expire) begin
          w_rsp_nxt[RSP_ERR] = 1'b1;
          w_fault_set        = 1'b1;
          w_fault_is_to      = 1'b1;
          w_stb_nxt          = '0;
          w_state_nxt        = ST_RESP;
        end else begin
          w_wd_nxt = r_wd + TW'(1);
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_fault_set && !r_fault) begin
      w_fault_nxt     = 1'b1;
      w_fault_adr_nxt = r_adr;
      w_fault_to_nxt  = w_fault_is_to;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_stb       <= '0;
      r_wd        <= '0;
      r_rsp       <= '0;
      r_rdat      <= '0;
      r_fault     <= 1'b0;
      r_fault_adr <= '0;
      r_fault_to  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_dat_nxt;
      r_sel       <= w_sel_nxt;
      r_we        <= w_we_nxt;
      r_idx       <= w_idx_nxt;
      r_stb       <= w_stb_nxt;
      r_wd        <= w_wd_nxt;
      r_rsp       <= w_rsp_nxt;
      r_rdat      <= w_rdat_nxt;
      r_fault     <= w_fault_nxt;
      r_fault_adr <= w_fault_adr_nxt;
      r_fault_to  <= w_fault_to_nxt;
    end
  end

  // Gating with the master cycle lets an abort release the slave immediately.
  assign wbs_stb_o   = r_stb & {NUM_SLAVES{wbm_cyc_i}};
  assign wbs_cyc_o   = r_stb & {NUM_SLAVES{wbm_cyc_i}};
  assign wbs_adr_o   = {NUM_SLAVES{r_adr}};
  assign wbs_dat_o   = {NUM_SLAVES{r_dat}};
  assign wbs_sel_o   = {NUM_SLAVES{r_sel}};
  assign wbs_we_o    = {NUM_SLAVES{r_we}};

  assign wbm_dat_o   = r_rdat;
  assign wbm_ack_o   = r_rsp[RSP_ACK];
  assign wbm_err_o   = r_rsp[RSP_ERR];
  assign wbm_rty_o   = r_rsp[RSP_RTY];
  assign fault_o     = r_fault;
  assign fault_adr_o = r_fault_adr;
  assign fault_to_o  = r_fault_to;

endmodule

// File: tb/tb_wb_decode_xbar.sv
// Scoreboard bench for wb_decode_xbar: expectations are queued when a request
// is issued and retired when the master-side response appears.
module tb_wb_decode_xbar;

  localparam int unsigned NS = 5;
  localparam int unsigned TO = 8;
  localparam int K_ACK   = 0;
  localparam int K_ERR   = 1;
  localparam int K_RTY   = 2;
  localparam int K_NEVER = 3;
  // slave4 = 0x0000xxxx overlaps slaves 0 and 1 but has the lowest priority
  localparam logic [NS*32-1:0] M_ADDR = {32'h0000_0000, 32'h0002_0000, 32'h0001_0000,
                                         32'h0000_1000, 32'h0000_0000};
  localparam logic [NS*32-1:0] M_MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                         32'hFFFF_F000, 32'hFFFF_F000};

  logic             clk;
  logic             rst;
  logic [31:0]      wbm_adr_i;
  logic [31:0]      wbm_dat_i;
  logic [3:0]       wbm_sel_i;
  logic             wbm_we_i;
  logic             wbm_stb_i;
  logic             wbm_cyc_i;
  logic [31:0]      wbm_dat_o;
  logic             wbm_ack_o;
  logic             wbm_err_o;
  logic             wbm_rty_o;
  logic [NS*32-1:0] wbs_adr_o;
  logic [NS*32-1:0] wbs_dat_o;
  logic [NS*4-1:0]  wbs_sel_o;
  logic [NS-1:0]    wbs_we_o;
  logic [NS-1:0]    wbs_stb_o;
  logic [NS-1:0]    wbs_cyc_o;
  logic [NS*32-1:0] wbs_dat_i;
  logic [NS-1:0]    wbs_ack_i;
  logic [NS-1:0]    wbs_err_i;
  logic [NS-1:0]    wbs_rty_i;
  logic             fault_o;
  logic [31:0]      fault_adr_o;
  logic             fault_to_o;

  wb_decode_xbar #(
    .NUM_SLAVES (NS),
    .AW         (32),
    .DW         (32),
    .MATCH_ADDR (M_ADDR),
    .MATCH_MASK (M_MASK),
    .TIMEOUT    (TO),
    .TW         (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbm_adr_i   (wbm_adr_i),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_sel_i   (wbm_sel_i),
    .wbm_we_i    (wbm_we_i),
    .wbm_stb_i   (wbm_stb_i),
    .wbm_cyc_i   (wbm_cyc_i),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_ack_o   (wbm_ack_o),
    .wbm_err_o   (wbm_err_o),
    .wbm_rty_o   (wbm_rty_o),
    .wbs_adr_o   (wbs_adr_o),
    .wbs_dat_o   (wbs_dat_o),
    .wbs_sel_o   (wbs_sel_o),
    .wbs_we_o    (wbs_we_o),
    .wbs_stb_o   (wbs_stb_o),
    .wbs_cyc_o   (wbs_cyc_o),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_i   (wbs_ack_i),
    .wbs_err_i   (wbs_err_i),
    .wbs_rty_i   (wbs_rty_i),
    .fault_o     (fault_o),
    .fault_adr_o (fault_adr_o),
    .fault_to_o  (fault_to_o)
  );

  typedef struct {
    logic [2:0]    rsp;     // {rty, err, ack}
    logic [31:0]   rdat;
    bit            chk_dat;
    logic [NS-1:0] mask;
    int            lat;
    logic [31:0]   adr;
    logic [31:0]   wdat;
    logic [3:0]    sel;
    logic          we;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            rsp_cnt  = 0;
  int            mon_lat  = 0;
  logic [NS-1:0] acc_stb;
  logic [31:0]   obs_adr;
  logic [31:0]   obs_dat;
  logic [3:0]    obs_sel;
  logic          obs_we;
  int            sl_kind[NS];
  int            sl_lat[NS];
  int            sl_cnt[NS];
  logic [31:0]   sl_dat[NS];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One cycle: sample at the falling edge, retire responses, then drive slave replies.
  task automatic tick();
    exp_t       e;
    logic [2:0] code;
    @(negedge clk);
    if (sb.size() != 0) mon_lat++;
    acc_stb = acc_stb | wbs_stb_o;
    for (int i = 0; i < int'(NS); i++) begin
      if (wbs_stb_o[i]) begin
        obs_adr = wbs_adr_o[i*32 +: 32];
        obs_dat = wbs_dat_o[i*32 +: 32];
        obs_sel = wbs_sel_o[i*4 +: 4];
        obs_we  = wbs_we_o[i];
      end
    end
    if (wbs_stb_o != '0) check_eq("cyc_eq_stb", 64'(wbs_cyc_o), 64'(wbs_stb_o));
    code = {wbm_rty_o, wbm_err_o, wbm_ack_o};
    if (code != 3'b000) begin
      rsp_cnt++;
      check_eq("rsp_onehot", 64'($countones(code)), 64'd1);
      if (sb.size() == 0) begin
        check_eq("unexpected_rsp", 64'(code), 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("rsp_code", 64'(code), 64'(e.rsp));
        if (e.chk_dat) check_eq("rd_dat", 64'(wbm_dat_o), 64'(e.rdat));
        check_eq("stb_mask", 64'(acc_stb), 64'(e.mask));
        check_eq("latency", 64'(mon_lat), 64'(e.lat));
        if (e.mask != '0) begin
          check_eq("slv_adr", 64'(obs_adr), 64'(e.adr));
          check_eq("slv_we", 64'(obs_we), 64'(e.we));
          check_eq("slv_sel", 64'(obs_sel), 64'(e.sel));
          if (e.we) check_eq("slv_wdat", 64'(obs_dat), 64'(e.wdat));
        end
      end
    end
    for (int i = 0; i < int'(NS); i++) begin
      wbs_ack_i[i] = 1'b0;
      wbs_err_i[i] = 1'b0;
      wbs_rty_i[i] = 1'b0;
      if (wbs_stb_o[i] && sl_kind[i] != K_NEVER) begin
        if (sl_cnt[i] == sl_lat[i]) begin
          wbs_ack_i[i] = (sl_kind[i] == K_ACK);
          wbs_err_i[i] = (sl_kind[i] == K_ERR);
          wbs_rty_i[i] = (sl_kind[i] == K_RTY);
        end
        sl_cnt[i]++;
      end else begin
        sl_cnt[i] = 0;
      end
      wbs_dat_i[i*32 +: 32] = sl_dat[i];
    end
  endtask

  // tgt < 0 means no slave decodes the address.
  task automatic issue(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                       input logic [3:0] sel, input int tgt, input int kind, input int lat);
    exp_t e;
    e.adr = adr; e.we = we; e.wdat = wdat; e.sel = sel;
    e.chk_dat = 1'b0; e.rdat = '0;
    if (tgt < 0) begin
      e.rsp = 3'b010; e.mask = '0; e.lat = 2;
    end else begin
      sl_kind[tgt] = kind;
      sl_lat[tgt]  = lat;
      e.mask = NS'(1) << tgt;
      e.rdat = sl_dat[tgt];
      case (kind)
        K_ACK:   begin e.rsp = 3'b001; e.chk_dat = !we; e.lat = 3 + lat; end
        K_ERR:   begin e.rsp = 3'b010; e.lat = 3 + lat; end
        K_RTY:   begin e.rsp = 3'b100; e.lat = 3 + lat; end
        default: begin e.rsp = 3'b010; e.lat = 2 + int'(TO); end
      endcase
    end
    sb.push_back(e);
    mon_lat = 0;
    acc_stb = '0;
    wbm_adr_i = adr; wbm_we_i = we; wbm_dat_i = wdat; wbm_sel_i = sel;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
  endtask

  task automatic wait_rsp();
    int n0;
    int k;
    n0 = rsp_cnt;
    k  = 0;
    while (rsp_cnt == n0 && k < 64) begin
      tick();
      k++;
    end
    check_eq("rsp_arrived", 64'(rsp_cnt - n0), 64'd1);
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_we_i = 1'b0;
    tick();
    check_eq("rsp_one_cycle", 64'({wbm_rty_o, wbm_err_o, wbm_ack_o}), 64'd0);
    check_eq("stb_released", 64'(wbs_stb_o), 64'd0);
  endtask

  task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                      input logic [3:0] sel, input int tgt, input int kind, input int lat);
    issue(adr, we, wdat, sel, tgt, kind, lat);
    wait_rsp();
  endtask

  task automatic wait_stb();
    int k;
    k = 0;
    while (wbs_stb_o == '0 && k < 8) begin
      tick();
      k++;
    end
  endtask

  function automatic logic [31:0] adr_for(input int tgt, input logic [31:0] r);
    case (tgt)
      0:       return {20'h00000, r[11:0]};
      1:       return {20'h00001, r[11:0]};
      2:       return {16'h0001, r[15:0]};
      3:       return {16'h0002, r[15:0]};
      default: return {16'h0000, 4'h2 + 4'(r[15:14]), r[11:0]};
    endcase
  endfunction

  initial begin
    int n0;
    int tgt;
    int kind;
    logic [31:0] r;
    rst = 1'b1;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 1'b0;
    wbm_stb_i = 1'b0; wbm_cyc_i = 1'b0;
    wbs_dat_i = '0; wbs_ack_i = '0; wbs_err_i = '0; wbs_rty_i = '0;
    acc_stb = '0; obs_adr = '0; obs_dat = '0; obs_sel = '0; obs_we = 1'b0;
    for (int i = 0; i < int'(NS); i++) begin
      sl_kind[i] = K_ACK; sl_lat[i] = 0; sl_cnt[i] = 0;
      sl_dat[i] = 32'h5A5A_0000 | 32'(i);
    end
    repeat (3) tick();
    check_eq("rst_ack_err_rty", 64'({wbm_rty_o, wbm_err_o, wbm_ack_o}), 64'd0);
    check_eq("rst_dat_o", 64'(wbm_dat_o), 64'd0);
    check_eq("rst_stb", 64'(wbs_stb_o), 64'd0);
    check_eq("rst_cyc", 64'(wbs_cyc_o), 64'd0);
    check_eq("rst_fault", 64'({fault_o, fault_to_o}), 64'd0);
    check_eq("rst_fault_adr", 64'(fault_adr_o), 64'd0);
    rst = 1'b0;
    tick();

    sl_dat[0] = 32'hCAFE_F00D;
    xfer(32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, K_ACK, 2);
    check_eq("dat_hold", 64'(wbm_dat_o), 64'hCAFE_F00D);

    sl_dat[1] = 32'h1111_2222;
    xfer(32'h0000_1000, 1'b0, 32'h0, 4'hF, 1, K_ACK, 0);
    xfer(32'h0000_4008, 1'b1, 32'hA5A5_1234, 4'h3, 4, K_ACK, 1);

    xfer(32'hDEAD_0000, 1'b0, 32'h0, 4'hF, -1, K_ACK, 0);
    check_eq("miss_fault", 64'(fault_o), 64'd1);
    check_eq("miss_fault_adr", 64'(fault_adr_o), 64'hDEAD_0000);
    check_eq("miss_fault_to", 64'(fault_to_o), 64'd0);

    sl_dat[3] = 32'h3333_4444;
    xfer(32'h0001_0200, 1'b0, 32'h0, 4'hF, 2, K_RTY, 1);
    xfer(32'h0002_0300, 1'b0, 32'h0, 4'hF, 3, K_ERR, 0);
    check_eq("slave_err_no_fault_adr", 64'(fault_adr_o), 64'hDEAD_0000);

    issue(32'h0001_0010, 1'b0, 32'h0, 4'hF, 2, K_NEVER, 0);
    wait_stb();
    check_eq("stb_before_reset", 64'(wbs_stb_o), 64'b00100);
    tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_stb", 64'({wbs_cyc_o, wbs_stb_o}), 64'd0);
    check_eq("midrst_rsp", 64'({wbm_rty_o, wbm_err_o, wbm_ack_o}), 64'd0);
    check_eq("midrst_dat_o", 64'(wbm_dat_o), 64'd0);
    check_eq("midrst_fault", 64'({fault_o, fault_to_o}), 64'd0);
    check_eq("midrst_fault_adr", 64'(fault_adr_o), 64'd0);
    sb.delete();
    rst = 1'b0; wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    tick();

    xfer(32'h0001_0040, 1'b0, 32'h0, 4'hF, 2, K_NEVER, 0);
    check_eq("to_fault", 64'(fault_o), 64'd1);
    check_eq("to_fault_adr", 64'(fault_adr_o), 64'h0001_0040);
    check_eq("to_fault_to", 64'(fault_to_o), 64'd1);
    xfer(32'h0003_0000, 1'b0, 32'h0, 4'hF, -1, K_ACK, 0);
    check_eq("second_fault_adr", 64'(fault_adr_o), 64'h0001_0040);
    check_eq("second_fault_to", 64'(fault_to_o), 64'd1);

    sl_dat[0] = 32'h0BAD_BEEF;
    xfer(32'h0000_0ABC, 1'b0, 32'h0, 4'hF, 0, K_ACK, int'(TO) - 1);

    issue(32'h0000_1004, 1'b1, 32'h7777_8888, 4'hF, 1, K_NEVER, 0);
    wait_stb();
    check_eq("stb_before_abort", 64'(wbs_stb_o), 64'b00010);
    repeat (2) tick();
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    #1;
    check_eq("abort_stb_drop", 64'({wbs_cyc_o, wbs_stb_o}), 64'd0);
    sb.delete();
    n0 = rsp_cnt;
    repeat (int'(TO) + 4) tick();
    check_eq("abort_no_rsp", 64'(rsp_cnt - n0), 64'd0);
    check_eq("abort_fault_adr", 64'(fault_adr_o), 64'h0001_0040);

    for (int k = 0; k < 16; k++) begin
      tgt  = int'($urandom_range(0, 4));
      r    = $urandom;
      kind = int'($urandom_range(0, 5));
      kind = (kind < 4) ? K_ACK : ((kind == 4) ? K_ERR : K_RTY);
      sl_dat[tgt] = $urandom;
      xfer(adr_for(tgt, r), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)),
           tgt, kind, int'($urandom_range(0, 3)));
    end
    check_eq("final_fault_adr", 64'(fault_adr_o), 64'h0001_0040);
    check_eq("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
